priority_decoder: RTL

Inverse of the priority encoder: accepts a stream of encoded words (index `y`, valid flag `z`) over a valid/ready handshake and returns the corresponding one-hot request vector `w`. It sits downstream of the encoder, for example to turn an encoded grant back into a one-hot select. A 2-entry skid buffer on the output gives full throughput with registered outputs. Indices outside `0..N-1` are flagged rather than decoded.

---
 rtl/priority_decoder.sv | 102 ++++++++++
 1 files changed

// File: rtl/priority_decoder.sv
// Decodes an encoded (index, any) word back into a one-hot vector, with a
// two-entry skid buffer so the outputs are registered at full throughput.
module priority_decoder #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] y,
    input  logic         z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] w,
    output logic         err,
    output logic         err_sticky
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic         err;
        logic [N-1:0] w;
    } word_t;

    // One extra bit so the bound itself is representable when N is a power of 2.
    localparam logic [W:0] N_LIM = (W+1)'(N);

    state_t state_q, state_d;
    word_t  main_q, main_d;
    word_t  skid_q, skid_d;
    logic   sticky_q, sticky_d;
    word_t  dec;
    logic   acc, hand;

    always_comb begin
        dec = '0;
        for (int i = 0; i < N; i++) begin
            dec.w[i] = z && (y == W'(i));
        end
        dec.err = z && ({1'b0, y} >= N_LIM);
    end

    // in_ready is a function of state only; rst masks it so nothing is taken
    // on a reset cycle.
    assign in_ready  = !rst && (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid && in_ready;
    assign hand      = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        sticky_d = sticky_q | (acc && dec.err);
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    main_d  = dec;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && hand) begin
                    main_d = dec;
                end else if (acc) begin
                    skid_d  = dec;
                    state_d = TWO;
                end else if (hand) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (hand) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            sticky_q <= sticky_d;
        end
    end

    assign w          = main_q.w;
    assign err        = main_q.err;
    assign err_sticky = sticky_q;

endmodule
